conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
Streaming sliding-window generator that produces the KH x KW x IN_CH input patches consumed by conv2d.
- Accepts one multi-channel pixel per handshake, in raster order, for an IMG_H x IMG_W frame.
- Stores the previous KH-1 rows in line buffers.
- Emits one registered patch per valid output position: stride 1, no padding.
- Sits between the feature-map source (DMA or previous layer) and the combinational conv2d array.

Parameters:
IN_CH, 1, channels per pixel beat
KH, 3, window height (1 <= KH <= IMG_H)
KW, 3, window width (1 <= KW <= IMG_W)
DATA_WIDTH, 16, signed pixel width
IMG_W, 8, frame width in pixels
IMG_H, 8, frame height in pixels

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_pix valid
in_ready  out  1  block can accept in_pix
in_pix  in  signed [DATA_WIDTH-1:0] x [IN_CH]  pixel, all channels
out_valid  out  1  out_patch valid
out_ready  in  1  downstream accepts patch
out_patch  out  signed [DATA_WIDTH-1:0] x [IN_CH][KH][KW]  window, same layout as conv2d in_patch
out_row  out  max(1,$clog2(IMG_H))  top-left row of patch
out_col  out  max(1,$clog2(IMG_W))  top-left column of patch
out_last  out  1  patch is last of frame

Behaviour:
Reset (asynchronous, rst_n=0):
- row = 0, col = 0.
- out_valid = 0, out_last = 0, out_row = 0, out_col = 0.
- out_patch all zeros.
- Line-buffer and window storage need not be reset.

Handshake and acceptance:
- in_ready = !out_valid || out_ready (combinational; single output register, no skid).
- A pixel is accepted when in_valid && in_ready.
- Nothing changes on cycles without acceptance.

Position counters:
- Each accepted pixel sits at position (row, col).
- After acceptance: col increments; at IMG_W-1 it wraps to 0 and row increments.
- At (IMG_H-1, IMG_W-1) both wrap to 0; the next frame starts with no idle cycle.

Line buffers and window:
- KH-1 line buffers of IMG_W entries x IN_CH channels, indexed by col.
- On acceptance, the column at col is shifted up: buffer k takes the old value of buffer k+1, and the top buffer takes in_pix.
- A KH x KW window register shifts left by one column. The new right column is {line buffers at col (oldest first), in_pix}.
- KH=1: no line buffers.

Patch emission:
- Emit when the accepted pixel has row >= KH-1 and col >= KW-1.
- On the next edge: out_valid = 1, out_row = row-KH+1, out_col = col-KW+1.
- out_last = 1 iff (row, col) = (IMG_H-1, IMG_W-1).
- out_patch[c][ky][kx] = channel c of pixel (out_row+ky, out_col+kx): ky=KH-1 is the newest row, kx=KW-1 the newest column.
- Latency: one cycle from accepting the triggering pixel to out_valid.

Output hold and clear:
- While out_valid && !out_ready, all out_* stay stable and in_ready = 0.
- out_valid clears on out_ready if the same cycle accepts no patch-triggering pixel.
- If it does accept one (simultaneous consume and produce), out_valid stays 1 and the new patch loads.

Frame accounting:
- Patches per frame = (IMG_H-KH+1) x (IMG_W-KW+1), in raster order of top-left position.
- Stale window columns at each row start are flushed by the col >= KW-1 gate.
- Stale line data at each frame start is masked by the row >= KH-1 gate.

Arithmetic and reset mid-frame:
- No arithmetic on pixel data; values pass bit-exact, sign preserved.
- Reset mid-frame discards the partial frame; the first pixel accepted after release is (0,0).

Test Plan:
1. IMG_W=5, IMG_H=4, KH=KW=3, IN_CH=1, pixel=row*16+col, out_ready=1, in_valid=1 continuously.
   -> first out_valid one cycle after accepting pixel 12 (2,2).
   -> patch {0,1,2;16,17,18;32,33,34}, out_row=0, out_col=0.
   -> exactly 6 patches; last patch at (1,2) = {18,19,20;34,35,36;50,51,52} with out_last=1.
2. Same setup, out_ready held 0 for 5 cycles while out_valid=1.
   -> out_patch/out_row/out_col stable, in_ready=0, no pixel consumed.
   -> after release, the patch sequence is identical to scenario 1.
3. in_valid random ~50% duty.
   -> patch contents, order and count identical to scenario 1; no duplicated or dropped patch.
4. Two frames back-to-back (frame 2 pixel = 200+row*16+col).
   -> frame 2 first patch at (0,0) = {200,201,202;216,217,218;232,233,234}.
   -> no patch mixes frame 1 data.
5. rst_n pulsed low after 9 pixels of frame 1, then a full frame sent.
   -> out_valid=0 and outputs zero during reset; output matches scenario 1 exactly.
6. IN_CH=2, channel 1 = -(row*16+col), KH=KW=2.
   -> first patch channel 1 = {0,-1;-16,-17} sign-exact.
   -> channel 0 = {0,1;16,17}.
   -> 12 patches for a 5x4 frame.

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming sliding-window generator for conv2d.
// Pixels arrive one per handshake in raster order. KH-1 line buffers hold the
// previous rows; a KH x KW window register slides left one column per pixel,
// and a registered patch is emitted for every full stride-1 window position.
module conv_window_gen #(
  parameter int IN_CH      = 1,
  parameter int KH         = 3,
  parameter int KW         = 3,
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  localparam int RW = ($clog2(IMG_H) > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = ($clog2(IMG_W) > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_pix    [IN_CH],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_patch [IN_CH][KH][KW],
  output logic        [RW-1:0]         out_row,
  output logic        [CW-1:0]         out_col,
  output logic                         out_last
);

  // Keep at least one buffer slot so the array is legal when KH == 1.
  localparam int LB_N = (KH > 1) ? KH - 1 : 1;

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  logic signed [DATA_WIDTH-1:0] lb_q        [LB_N][IMG_W][IN_CH];
  logic signed [DATA_WIDTH-1:0] win_q       [IN_CH][KH][KW];
  logic signed [DATA_WIDTH-1:0] win_sh      [IN_CH][KH][KW];
  logic signed [DATA_WIDTH-1:0] out_patch_q [IN_CH][KH][KW];

  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;

  logic accept;
  logic emit;
  logic col_end;
  logic row_end;

  // Single output register without skid: a new pixel may only enter when the
  // held patch is gone or being taken this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col_q == CW'(IMG_W - 1));
  assign row_end  = (row_q == RW'(IMG_H - 1));
  // The row gate masks stale line data at frame start; the column gate
  // flushes stale window columns left over from the previous row.
  assign emit     = accept && (row_q >= RW'(KH - 1)) && (col_q >= CW'(KW - 1));

  // Window shifted by one column, new right column = {line buffers oldest first, in_pix}.
  always_comb begin
    win_sh = win_q;
    for (int c = 0; c < IN_CH; c++) begin
      for (int ky = 0; ky < KH; ky++) begin
        for (int kx = 0; kx < KW - 1; kx++) begin
          win_sh[c][ky][kx] = win_q[c][ky][kx+1];
        end
      end
      for (int ky = 0; ky < KH - 1; ky++) begin
        win_sh[c][ky][KW-1] = lb_q[ky][col_q][c];
      end
      win_sh[c][KH-1][KW-1] = in_pix[c];
    end
  end

  // Position counters and output-register next state.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_row_d   = row_q - RW'(KH - 1);
      out_col_d   = col_q - CW'(KW - 1);
      out_last_d  = row_end && col_end;
    end
  end

  // Control and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  // Registered patch: loads the freshly shifted window when a position completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < IN_CH; c++) begin
        for (int ky = 0; ky < KH; ky++) begin
          for (int kx = 0; kx < KW; kx++) begin
            out_patch_q[c][ky][kx] <= '0;
          end
        end
      end
    end else if (emit) begin
      out_patch_q <= win_sh;
    end
  end

  // Window storage; its contents are only observed through gated patches.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_sh;
    end
  end

  generate
    if (KH > 1) begin : g_lb
      // Line buffers: the column at col shifts up, newest row enters at the top.
      always_ff @(posedge clk) begin
        if (accept) begin
          for (int c = 0; c < IN_CH; c++) begin
            for (int k = 0; k < KH - 2; k++) begin
              lb_q[k][col_q][c] <= lb_q[k+1][col_q][c];
            end
            lb_q[KH-2][col_q][c] <= in_pix[c];
          end
        end
      end
    end else begin : g_no_lb
      // Single-row window needs no history.
      always_comb begin
        for (int x = 0; x < IMG_W; x++) begin
          for (int c = 0; c < IN_CH; c++) begin
            lb_q[0][x][c] = '0;
          end
        end
      end
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_patch = out_patch_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed bench for the sliding-window generator.
// Instance A: 5x4 frame, 3x3 window, 1 channel. Instance B: 5x4 frame, 2x2
// window, 2 channels. Expected patches are queued when the triggering pixel is
// accepted and compared when the DUT presents them.
module tb_conv_window_gen;
  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic signed [DW-1:0] a_in_pix    [1];
  logic signed [DW-1:0] a_out_patch [1][3][3];
  logic [1:0]           a_out_row;
  logic [2:0]           a_out_col;

  logic                 b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic signed [DW-1:0] b_in_pix    [2];
  logic signed [DW-1:0] b_out_patch [2][2][2];
  logic [1:0]           b_out_row;
  logic [2:0]           b_out_col;

  conv_window_gen #(.IN_CH(1), .KH(3), .KW(3), .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pix(a_in_pix),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_patch(a_out_patch),
    .out_row(a_out_row), .out_col(a_out_col), .out_last(a_out_last));

  conv_window_gen #(.IN_CH(2), .KH(2), .KW(2), .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pix(b_in_pix),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_patch(b_out_patch),
    .out_row(b_out_row), .out_col(b_out_col), .out_last(b_out_last));

  typedef struct {
    int base;
    int orow;
    int ocol;
    bit last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   a_pops  = 0;
  int   b_pops  = 0;
  bit   a_lat   = 1'b0;
  bit   a_lat_exp = 1'b0;

  function automatic int pixv(input int base, input int r, input int c);
    return base + r * 16 + c;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // out_valid one cycle after an accepted pixel must equal "that pixel completed a window".
  task automatic a_lat_check();
    if (a_lat) begin
      chk("a_latency", a_out_valid, a_lat_exp);
      a_lat = 1'b0;
    end
  endtask

  // Scoreboard for A: every presented patch is popped and checked pixel by pixel.
  always @(negedge clk) begin
    if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      n_tests++;
      assert (qa.size() > 0) else begin
        n_fail++;
        $error("FAIL a_extra_patch: observed patch at row %0d col %0d expected none", a_out_row, a_out_col);
      end
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        a_pops++;
        chk("a_row", a_out_row, ea.orow);
        chk("a_col", a_out_col, ea.ocol);
        chk("a_last", a_out_last, ea.last);
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            chk("a_pix", a_out_patch[0][ky][kx], pixv(ea.base, ea.orow + ky, ea.ocol + kx));
      end
    end
  end

  // Scoreboard for B: channel 0 carries +value, channel 1 carries -value.
  always @(negedge clk) begin
    if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      n_tests++;
      assert (qb.size() > 0) else begin
        n_fail++;
        $error("FAIL b_extra_patch: observed patch at row %0d col %0d expected none", b_out_row, b_out_col);
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        b_pops++;
        chk("b_row", b_out_row, eb.orow);
        chk("b_col", b_out_col, eb.ocol);
        chk("b_last", b_out_last, eb.last);
        for (int ky = 0; ky < 2; ky++)
          for (int kx = 0; kx < 2; kx++) begin
            chk("b_ch0", b_out_patch[0][ky][kx], pixv(0, eb.orow + ky, eb.ocol + kx));
            chk("b_ch1", b_out_patch[1][ky][kx], -pixv(0, eb.orow + ky, eb.ocol + kx));
          end
      end
    end
  end

  task automatic send_a(input int base, input int r, input int c, input bit rnd);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    if (rnd && $urandom_range(1) == 1) begin
      a_in_valid = 1'b0;
      @(negedge clk);
      a_lat_check();
      @(posedge clk); #1;
    end
    a_in_valid  = 1'b1;
    a_in_pix[0] = 16'(pixv(base, r, c));
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      a_lat_check();
      if (a_in_ready === 1'b1) begin
        acc = 1'b1;
        if (r >= 2 && c >= 2) begin
          e.base = base; e.orow = r - 2; e.ocol = c - 2; e.last = (r == H - 1 && c == W - 1);
          qa.push_back(e);
        end
        a_lat     = a_out_ready;
        a_lat_exp = (r >= 2 && c >= 2);
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    n_tests++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL a_accept_timeout: observed no acceptance of (%0d,%0d) expected acceptance", r, c);
    end
  endtask

  task automatic send_b(input int r, input int c);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    b_in_valid  = 1'b1;
    b_in_pix[0] = 16'(pixv(0, r, c));
    b_in_pix[1] = 16'(-pixv(0, r, c));
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (b_in_ready === 1'b1) begin
        acc = 1'b1;
        if (r >= 1 && c >= 1) begin
          e.base = 0; e.orow = r - 1; e.ocol = c - 1; e.last = (r == H - 1 && c == W - 1);
          qb.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    n_tests++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL b_accept_timeout: observed no acceptance of (%0d,%0d) expected acceptance", r, c);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) begin
      @(negedge clk);
      a_lat_check();
      @(posedge clk); #1;
    end
    @(negedge clk);
    a_lat_check();
    @(posedge clk); #1;
    n_tests++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d/%0d patches outstanding expected 0", qa.size(), qb.size());
    end
  endtask

  task automatic frame_a(input int base, input bit rnd, input bit hold);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (hold && r == 2 && c == 3) begin
          // Patch (0,0) is held with a new pixel waiting: nothing may move.
          a_out_ready = 1'b0;
          a_in_valid  = 1'b1;
          a_in_pix[0] = 16'(pixv(base, 2, 3));
          repeat (5) begin
            @(negedge clk);
            a_lat_check();
            chk("hold_in_ready", a_in_ready, 0);
            chk("hold_valid", a_out_valid, 1);
            chk("hold_row", a_out_row, 0);
            chk("hold_col", a_out_col, 0);
            chk("hold_p00", a_out_patch[0][0][0], 0);
            chk("hold_p12", a_out_patch[0][1][2], 18);
            chk("hold_p22", a_out_patch[0][2][2], 34);
            @(posedge clk); #1;
          end
          a_in_valid  = 1'b0;
          a_out_ready = 1'b1;
        end
        send_a(base, r, c, rnd);
      end
  endtask

  task automatic reset_checks();
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_last", a_out_last, 0);
    chk("rst_a_row", a_out_row, 0);
    chk("rst_a_col", a_out_col, 0);
    chk("rst_a_p00", a_out_patch[0][0][0], 0);
    chk("rst_a_p22", a_out_patch[0][2][2], 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_ch1", b_out_patch[1][1][1], 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  int pops0;

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_pix[0] = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_pix[0] = '0; b_in_pix[1] = '0;
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Continuous streaming, one frame.
    pops0 = a_pops;
    frame_a(0, 1'b0, 1'b0);
    drain();
    chk("s1_count", a_pops - pops0, 6);

    // Backpressure hold on the first patch.
    pops0 = a_pops;
    frame_a(0, 1'b0, 1'b1);
    drain();
    chk("s2_count", a_pops - pops0, 6);

    // Gappy input.
    pops0 = a_pops;
    frame_a(0, 1'b1, 1'b0);
    drain();
    chk("s3_count", a_pops - pops0, 6);

    // Two frames back to back; frame 2 must hold no frame 1 data.
    pops0 = a_pops;
    frame_a(0, 1'b0, 1'b0);
    frame_a(200, 1'b0, 1'b0);
    drain();
    chk("s4_count", a_pops - pops0, 12);

    // Reset after 9 pixels of a frame, then a clean frame.
    for (int i = 0; i < 9; i++) send_a(0, i / W, i % W, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks();
    qa.delete();
    a_lat = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pops0 = a_pops;
    frame_a(0, 1'b0, 1'b0);
    drain();
    chk("s5_count", a_pops - pops0, 6);

    // Two channels, 2x2 window, signed channel 1.
    pops0 = b_pops;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_b(r, c);
    drain();
    chk("s6_count", b_pops - pops0, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
